// File: rtl/cdu_pkg.sv
// cdu_pkg: shared widths, qualifier state encoding and angle scale for the CDU pulse counter
package cdu_pkg;
    localparam int CNT_W_DEFAULT = 15;
    localparam real ANGLE_LSB_DEG = 360.0 / 32768.0;
    typedef enum logic [1:0] {DISARMED, ARMED, COUNTING, DONE} qual_state_t;
endpackage

// File: rtl/cdu_pulse_qual.sv
// cdu_pulse_qual: synchronizes one async pulse line and emits one strobe per high interval of at least MIN_HIGH cycles
module cdu_pulse_qual
    import cdu_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int MIN_HIGH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic pulse,
    output logic ev
);
    localparam int RW = $clog2(MIN_HIGH + 1);
    logic [SYNC_STAGES-1:0] sync;
    logic [RW-1:0] run;
    logic [RW-1:0] run_nx;
    logic s_hi;
    logic hit;
    qual_state_t state;
    assign s_hi = sync[SYNC_STAGES-1];
    assign run_nx = (state == COUNTING) ? run + RW'(1) : RW'(1);
    assign hit = run_nx == RW'(MIN_HIGH);
    // Synchronizer resets high so a line held high through reset reads as high and never arms
    always_ff @(posedge clk)
        sync <= rst ? '1 : {sync[SYNC_STAGES-2:0], pulse};
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= DISARMED;
            run <= '0;
            ev <= 1'b0;
        end else begin
            ev <= 1'b0;
            case (state)
                ARMED, COUNTING: begin
                    if (s_hi) begin
                        run <= run_nx;
                        ev <= hit;
                        state <= hit ? DONE : COUNTING;
                    end else begin
                        state <= ARMED;
                    end
                end
                default: if (!s_hi) state <= ARMED;
            endcase
        end
    end
endmodule

// File: rtl/cdu_pulse_counter.sv
// cdu_pulse_counter: wrapping angle register fed by qualified CDU +/- pulses, with zero, snapshot and over-rate flag
module cdu_pulse_counter
    import cdu_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int MIN_HIGH = 4,
    parameter int MIN_GAP = 64,
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ATpPGH,
    input  logic             ATmPGH,
    input  logic             cnt_zero,
    input  logic             snap_req,
    output logic             snap_ack,
    output logic [CNT_W-1:0] snap_val,
    output logic [CNT_W-1:0] count,
    output logic             ev_p,
    output logic             ev_m,
    output logic             rate_err,
    input  logic             rate_err_clr
);
    localparam int GW = $clog2(MIN_GAP + 1);
    localparam logic [GW-1:0] GAP_SAT = GW'(MIN_GAP);
    logic [GW-1:0] gap;
    logic [CNT_W-1:0] snap_cap;
    logic snap_pend;
    logic ev_any;
    cdu_pulse_qual #(.SYNC_STAGES(SYNC_STAGES), .MIN_HIGH(MIN_HIGH)) u_qual_p (
        .clk(clk), .rst(rst), .pulse(ATpPGH), .ev(ev_p)
    );
    cdu_pulse_qual #(.SYNC_STAGES(SYNC_STAGES), .MIN_HIGH(MIN_HIGH)) u_qual_m (
        .clk(clk), .rst(rst), .pulse(ATmPGH), .ev(ev_m)
    );
    assign ev_any = ev_p | ev_m;
    // Snapshot captures the pre-update count, then presents it one edge later
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            gap <= GAP_SAT;
            rate_err <= 1'b0;
            snap_pend <= 1'b0;
            snap_cap <= '0;
            snap_ack <= 1'b0;
            snap_val <= '0;
        end else begin
            count <= cnt_zero ? '0 :
                     (ev_p & ~ev_m) ? count + CNT_W'(1) :
                     (ev_m & ~ev_p) ? count - CNT_W'(1) : count;
            gap <= ev_any ? '0 : (gap == GAP_SAT) ? gap : gap + GW'(1);
            rate_err <= (ev_any & (gap < GAP_SAT)) | (rate_err & ~rate_err_clr);
            snap_pend <= snap_req;
            snap_cap <= snap_req ? count : snap_cap;
            snap_ack <= snap_pend;
            snap_val <= snap_pend ? snap_cap : snap_val;
        end
    end
endmodule

// File: tb/tb_cdu_pulse_counter.sv
// tb_cdu_pulse_counter: directed and randomized checks of the CDU pulse counter against an arithmetic angle model
module tb_cdu_pulse_counter;
    logic clk, rst, at_p, at_m, cnt_zero, snap_req, snap_ack, ev_p, ev_m, rate_err, rate_err_clr;
    logic [14:0] snap_val, count;
    int n_cmp = 0, n_bad = 0;
    int np = 0, nm = 0;
    int exp_cnt = 0;
    cdu_pulse_counter dut (
        .clk(clk), .rst(rst), .ATpPGH(at_p), .ATmPGH(at_m), .cnt_zero(cnt_zero),
        .snap_req(snap_req), .snap_ack(snap_ack), .snap_val(snap_val), .count(count),
        .ev_p(ev_p), .ev_m(ev_m), .rate_err(rate_err), .rate_err_clr(rate_err_clr)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(negedge clk) begin
        if (ev_p) np++;
        if (ev_m) nm++;
    end
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    // One pulse on either line; the model counts it only if it lasts at least four cycles
    task automatic pulse(input bit pos, input int hi, input int lo);
        if (pos) at_p = 1'b1; else at_m = 1'b1;
        tick(hi);
        at_p = 1'b0;
        at_m = 1'b0;
        tick(lo);
        if (hi >= 4) exp_cnt = pos ? (exp_cnt + 1) % 32768 : (exp_cnt + 32767) % 32768;
    endtask
    initial begin
        int np0, nm0, base, exp_np, exp_nm;
        bit pos;
        int hi, lo;
        rst = 1'b1; at_p = 1'b0; at_m = 1'b0; cnt_zero = 1'b0; snap_req = 1'b0; rate_err_clr = 1'b0;
        tick(3);
        chk("rst_count", count, 0);
        chk("rst_snap_val", snap_val, 0);
        chk("rst_snap_ack", snap_ack, 0);
        chk("rst_ev", {ev_p, ev_m}, 0);
        chk("rst_rate_err", rate_err, 0);
        rst = 1'b0;
        tick(5);
        np0 = np;
        for (int i = 0; i < 384; i++) pulse(1, 10, 100);
        chk("p384_count", count, 15'h0180);
        chk("p384_strobes", np - np0, 384);
        chk("p384_rate_err", rate_err, 0);
        for (int i = 0; i < 93; i++) pulse(0, 4, 70);
        chk("down_to_123", count, 15'h0123);
        at_p = 1'b1;
        tick(4);
        at_p = 1'b0;
        tick(1);
        snap_req = 1'b1;
        tick(1);
        snap_req = 1'b0;
        chk("snap_ack_e6", snap_ack, 0);
        tick(1);
        chk("snap_ack_e7", snap_ack, 1);
        chk("snap_val_e7", snap_val, 15'h0123);
        chk("snap_count_e7", count, 15'h0124);
        tick(1);
        chk("snap_ack_e8", snap_ack, 0);
        chk("snap_val_hold", snap_val, 15'h0123);
        exp_cnt = 15'h0124;
        tick(70);
        np0 = np; nm0 = nm; exp_np = 0; exp_nm = 0;
        for (int i = 0; i < 40; i++) begin
            pos = 1'($urandom_range(0, 1));
            hi = int'($urandom_range(1, 12));
            lo = int'($urandom_range(70, 90));
            pulse(pos, hi, lo);
            if (hi >= 4) begin
                if (pos) exp_np++; else exp_nm++;
            end
            if (i % 4 == 0) begin
                snap_req = 1'b1;
                tick(1);
                snap_req = 1'b0;
                tick(1);
                chk("rnd_snap_ack", snap_ack, 1);
                chk("rnd_snap_val", snap_val, exp_cnt);
            end
        end
        chk("rnd_count", count, exp_cnt);
        chk("rnd_ev_p", np - np0, exp_np);
        chk("rnd_ev_m", nm - nm0, exp_nm);
        chk("rnd_rate_err", rate_err, 0);
        cnt_zero = 1'b1;
        tick(1);
        cnt_zero = 1'b0;
        tick(1);
        exp_cnt = 0;
        chk("zero", count, 0);
        pulse(0, 6, 70);
        chk("wrap_down", count, 15'h7FFF);
        pulse(1, 6, 70);
        chk("wrap_up", count, 0);
        base = exp_cnt;
        at_p = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick(1);
            if (k == 3) at_p = 1'b0;
            chk($sformatf("lat_ev_e%0d", k), ev_p, (k == 5));
            chk($sformatf("lat_cnt_e%0d", k), count, (k >= 6) ? base + 1 : base);
        end
        exp_cnt = base + 1;
        tick(70);
        np0 = np;
        pulse(1, 3, 70);
        chk("glitch3_count", count, exp_cnt);
        chk("glitch3_strobe", np - np0, 0);
        np0 = np;
        pulse(1, 50, 70);
        chk("wide50_count", count, exp_cnt);
        chk("wide50_strobe", np - np0, 1);
        np0 = np; nm0 = nm;
        at_p = 1'b1; at_m = 1'b1;
        tick(10);
        at_p = 1'b0; at_m = 1'b0;
        tick(70);
        chk("both_count", count, exp_cnt);
        chk("both_strobes", (np - np0) + (nm - nm0), 2);
        cnt_zero = 1'b1;
        tick(1);
        cnt_zero = 1'b0;
        exp_cnt = 0;
        for (int i = 0; i < 66; i++) pulse(1, 4, 70);
        chk("up_to_42", count, 15'h0042);
        at_p = 1'b1;
        tick(4);
        at_p = 1'b0;
        tick(2);
        chk("zero_coinc_ev", ev_p, 1);
        cnt_zero = 1'b1;
        tick(1);
        cnt_zero = 1'b0;
        chk("zero_coinc_e6", count, 0);
        tick(70);
        chk("zero_coinc_after", count, 0);
        exp_cnt = 0;
        chk("pre_rate_err", rate_err, 0);
        pulse(1, 10, 30);
        pulse(1, 10, 80);
        chk("rate_count", count, 2);
        chk("rate_err_set", rate_err, 1);
        rate_err_clr = 1'b1;
        tick(1);
        rate_err_clr = 1'b0;
        tick(1);
        chk("rate_err_clr", rate_err, 0);
        pulse(1, 10, 30);
        at_p = 1'b1;
        tick(6);
        chk("rate_pre_viol", rate_err, 0);
        rate_err_clr = 1'b1;
        tick(1);
        rate_err_clr = 1'b0;
        chk("rate_set_wins", rate_err, 1);
        tick(4);
        at_p = 1'b0;
        tick(70);
        chk("rate_count2", count, 4);
        at_p = 1'b1;
        tick(3);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(20);
        np0 = np;
        chk("rst_mid_count", count, 0);
        chk("rst_mid_rate_err", rate_err, 0);
        tick(20);
        chk("rst_held_count", count, 0);
        chk("rst_held_strobe", np - np0, 0);
        at_p = 1'b0;
        tick(10);
        chk("rst_drop_count", count, 0);
        exp_cnt = 0;
        pulse(1, 6, 70);
        chk("rst_new_pulse", count, exp_cnt);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
